// File: rtl/fsum_pack.sv
// Output packer for the full-sum accumulator: optional ReLU on each fp16 result,
// packs up to BURST_LEN results into one wide word, with one-word skid while the FIFO stalls.
module fsum_pack #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        relu_en,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [DATA_W*BURST_LEN-1:0] out_data,
  output logic [BURST_LEN-1:0]        out_mask,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        drop_err,
  output logic [15:0]                 words_out
);

  localparam int OUT_W = DATA_W * BURST_LEN;
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {FILL, PEND} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [OUT_W-1:0]     fill_q, fill_d;
  logic [BURST_LEN-1:0] pendMask_q, pendMask_d;
  logic [OUT_W-1:0]     outData_q, outData_d;
  logic [BURST_LEN-1:0] outMask_q, outMask_d;
  logic                 outValid_q, outValid_d;
  logic                 dropErr_q, dropErr_d;
  logic [15:0]          wordsOut_q, wordsOut_d;

  logic [DATA_W-1:0]    laneVal;
  logic [OUT_W-1:0]     newWord;
  logic [BURST_LEN-1:0] newMask;
  logic                 accept, handoff, complete;

  assign in_ready  = (state_q == FILL);
  assign out_data  = outData_q;
  assign out_mask  = outMask_q;
  assign out_valid = outValid_q;
  assign drop_err  = dropErr_q;
  assign words_out = wordsOut_q;

  // In PEND the fill register itself holds the frozen word, so no second word buffer is needed.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fill_d     = fill_q;
    pendMask_d = pendMask_q;
    outData_d  = outData_q;
    outMask_d  = outMask_q;
    outValid_d = outValid_q;
    dropErr_d  = dropErr_q;
    wordsOut_d = wordsOut_q;

    laneVal  = (relu_en && in_data[DATA_W-1]) ? '0 : in_data;
    accept   = in_valid && (state_q == FILL);
    handoff  = outValid_q && out_ready;
    complete = accept && (in_last || (count_q == CNT_W'(BURST_LEN - 1)));

    newWord = fill_q;
    newWord[int'(count_q)*DATA_W +: DATA_W] = laneVal;
    for (int k = 0; k < BURST_LEN; k++) begin
      newMask[k] = (k <= int'(count_q));
    end

    if (handoff) begin
      outValid_d = 1'b0;
      wordsOut_d = wordsOut_q + 16'd1;
    end

    if (in_valid && (state_q != FILL)) begin
      dropErr_d = 1'b1;
    end

    case (state_q)
      FILL: begin
        if (accept) begin
          if (!complete) begin
            fill_d  = newWord;
            count_d = count_q + CNT_W'(1);
          end else if (!outValid_q || handoff) begin
            outData_d  = newWord;
            outMask_d  = newMask;
            outValid_d = 1'b1;
            fill_d     = '0;
            count_d    = '0;
          end else begin
            fill_d     = newWord;
            pendMask_d = newMask;
            state_d    = PEND;
          end
        end
      end
      PEND: begin
        if (handoff) begin
          outData_d  = fill_q;
          outMask_d  = pendMask_q;
          outValid_d = 1'b1;
          fill_d     = '0;
          count_d    = '0;
          state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      count_q    <= '0;
      fill_q     <= '0;
      pendMask_q <= '0;
      outData_q  <= '0;
      outMask_q  <= '0;
      outValid_q <= 1'b0;
      dropErr_q  <= 1'b0;
      wordsOut_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fill_q     <= fill_d;
      pendMask_q <= pendMask_d;
      outData_q  <= outData_d;
      outMask_q  <= outMask_d;
      outValid_q <= outValid_d;
      dropErr_q  <= dropErr_d;
      wordsOut_q <= wordsOut_d;
    end
  end

endmodule
